// File: rtl/rst_ctrl.sv
// System reset controller: merges board, watchdog and software reset sources into one
// stretched reset, and keeps a sticky reset-cause register plus a saturating watchdog-reset count.
module rst_ctrl #(
  parameter int          HOLD_CYCLES = 16,
  parameter logic [15:0] SW_KEY      = 16'h5A5A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wdt_rst_in,
  input  logic        Select,
  input  logic        Address,
  input  logic        Read_enable,
  input  logic        Write_enable,
  input  logic [15:0] Write_data_in,
  output logic [15:0] Read_data_out,
  output logic        sys_rst
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int               CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             wdt_prev;
  logic             wdt_evt, sw_evt, any_evt, cause_wr;
  logic [2:0]       cause, cause_nxt;
  logic [15:0]      wdt_count;

  // Edge detect: a watchdog pulse of any length counts as a single event.
  assign wdt_evt  = wdt_rst_in & ~wdt_prev;
  assign sw_evt   = Select & Write_enable & Address & (Write_data_in == SW_KEY);
  assign any_evt  = wdt_evt | sw_evt;
  assign cause_wr = Select & Write_enable & ~Address;

  // HOLD encodes as 1, so sys_rst is a flop output and cannot glitch.
  assign sys_rst = (state == HOLD);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      HOLD: begin
        if (any_evt)               hold_cnt_nxt = CNT_RELOAD;
        else if (hold_cnt == '0)   state_nxt    = RUN;
        else                       hold_cnt_nxt = hold_cnt - CNT_W'(1);
      end
      RUN: begin
        if (any_evt) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = CNT_RELOAD;
        end
      end
    endcase
  end

  // Write-1-to-clear first, then new events are OR-ed in so a same-cycle set wins.
  always_comb begin
    cause_nxt = cause;
    if (cause_wr) cause_nxt = cause & ~Write_data_in[2:0];
    cause_nxt = cause_nxt | {sw_evt, wdt_evt, 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= HOLD;
      hold_cnt      <= CNT_RELOAD;
      wdt_prev      <= 1'b0;
      cause         <= 3'b001;
      wdt_count     <= '0;
      Read_data_out <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      wdt_prev <= wdt_rst_in;
      cause    <= cause_nxt;
      if (wdt_evt && (wdt_count != 16'hFFFF)) wdt_count <= wdt_count + 16'd1;
      // Reads sample the current registers, so a same-cycle write is not yet visible.
      if (Select && Read_enable)
        Read_data_out <= Address ? wdt_count : {13'd0, cause};
    end
  end

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed self-checking bench for rst_ctrl: reset stretching, cause register,
// watchdog counter saturation and bus read/write corner cases.
module tb_rst_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wdt_rst_in;
  logic        Select;
  logic        Address;
  logic        Read_enable;
  logic        Write_enable;
  logic [15:0] Write_data_in;
  logic [15:0] Read_data_out;
  logic        sys_rst;

  int n_cmp = 0;
  int n_err = 0;

  rst_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .wdt_rst_in    (wdt_rst_in),
    .Select        (Select),
    .Address       (Address),
    .Read_enable   (Read_enable),
    .Write_enable  (Write_enable),
    .Write_data_in (Write_data_in),
    .Read_data_out (Read_data_out),
    .sys_rst       (sys_rst)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus_write(input logic addr, input logic [15:0] data);
    Select = 1'b1; Write_enable = 1'b1; Address = addr; Write_data_in = data;
    tick();
    Select = 1'b0; Write_enable = 1'b0; Write_data_in = '0;
  endtask

  task automatic bus_read(input logic addr, output logic [15:0] data);
    Select = 1'b1; Read_enable = 1'b1; Address = addr;
    tick();
    data = Read_data_out;
    Select = 1'b0; Read_enable = 1'b0;
  endtask

  // Counts cycles until sys_rst drops, bounded so a stuck reset cannot hang the run.
  task automatic measure_hold(output int n);
    n = 0;
    while (sys_rst && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int          n, m;

    reset = 1'b0; wdt_rst_in = 1'b0; Select = 1'b0; Address = 1'b0;
    Read_enable = 1'b0; Write_enable = 1'b0; Write_data_in = '0;

    // 1: power-on reset and release
    repeat (3) tick();
    check("por_sys_rst", sys_rst, 1);
    check("por_rdata", Read_data_out, 16'h0000);
    reset = 1'b1;
    measure_hold(n);
    check("por_hold_len", n, 16);
    bus_read(1'b0, rd);
    check("por_cause", rd, 16'h0001);
    bus_read(1'b1, rd);
    check("por_wdt_count", rd, 16'h0000);

    // 2: 4-cycle watchdog pulse in RUN
    check("run_before_wdt", sys_rst, 0);
    wdt_rst_in = 1'b1;
    tick();
    check("wdt_rise", sys_rst, 1);
    n = 0;
    repeat (3) begin tick(); n++; end
    wdt_rst_in = 1'b0;
    measure_hold(m);
    check("wdt_hold_len", n + m, 16);
    bus_read(1'b0, rd);
    check("wdt_cause", rd, 16'h0003);
    bus_read(1'b1, rd);
    check("wdt_count_one", rd, 16'h0001);

    // 3: W1C, wrong key, correct key
    bus_write(1'b0, 16'h0003);
    bus_read(1'b0, rd);
    check("w1c_cause", rd, 16'h0000);
    bus_write(1'b1, 16'h1234);
    check("bad_key_no_rst", sys_rst, 0);
    tick();
    check("bad_key_still_run", sys_rst, 0);
    bus_write(1'b1, 16'h5A5A);
    check("sw_rise", sys_rst, 1);
    bus_read(1'b0, rd);
    check("sw_cause", rd, 16'h0004);
    measure_hold(m);
    check("sw_hold_len", 1 + m, 16);

    // 4: second watchdog edge 5 cycles into HOLD reloads the counter
    wdt_rst_in = 1'b1;
    tick();
    wdt_rst_in = 1'b0;
    repeat (4) tick();
    check("mid_hold_high", sys_rst, 1);
    wdt_rst_in = 1'b1;
    tick();
    wdt_rst_in = 1'b0;
    measure_hold(m);
    check("reload_hold_len", m, 16);
    bus_read(1'b1, rd);
    check("wdt_count_three", rd, 16'h0003);

    // 5: same-cycle clear and set, then read-during-write
    wdt_rst_in = 1'b1;
    bus_write(1'b0, 16'h0002);
    wdt_rst_in = 1'b0;
    bus_read(1'b0, rd);
    check("set_wins_cause", rd, 16'h0006);
    bus_write(1'b0, 16'h0004);
    bus_read(1'b0, rd);
    check("clear_sw_bit", rd, 16'h0002);
    Select = 1'b1; Read_enable = 1'b1; Write_enable = 1'b1; Address = 1'b0; Write_data_in = 16'h0002;
    tick();
    Select = 1'b0; Read_enable = 1'b0; Write_enable = 1'b0; Write_data_in = '0;
    check("rw_prewrite", Read_data_out, 16'h0002);
    bus_read(1'b0, rd);
    check("rw_postwrite", rd, 16'h0000);
    measure_hold(m);
    check("back_to_run", sys_rst, 0);

    // 6: saturation, then reset clears everything
    force dut.wdt_count = 16'hFFFE;
    #1;
    release dut.wdt_count;
    wdt_rst_in = 1'b1;
    tick();
    wdt_rst_in = 1'b0;
    tick();
    bus_read(1'b1, rd);
    check("count_reach_max", rd, 16'hFFFF);
    wdt_rst_in = 1'b1;
    tick();
    wdt_rst_in = 1'b0;
    tick();
    bus_read(1'b1, rd);
    check("count_saturate", rd, 16'hFFFF);
    reset = 1'b0;
    tick();
    check("rst_rdata_clear", Read_data_out, 16'h0000);
    check("rst_sys_rst", sys_rst, 1);
    tick();
    reset = 1'b1;
    bus_read(1'b1, rd);
    check("rst_wdt_count", rd, 16'h0000);
    bus_read(1'b0, rd);
    check("rst_cause", rd, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rst_ctrl.md
Name: rst_ctrl

Overview:
- System reset controller directly downstream of the watchdog timer: consumes the WDT's 4-cycle reset pulse, the board reset and a software reset request, and produces one stretched, glitch-free reset for the CPU core, the WDT and the peripherals.
- Records the cause of the last reset and counts watchdog resets in two 16-bit registers on the IO bus, so boot code can tell a POR from a watchdog recovery.

Parameters:
- HOLD_CYCLES, 16, number of cycles sys_rst stays asserted after the last reset event (min 1).
- SW_KEY, 16'h5A5A, value that must be written to the control register to request a software reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low board/power-on reset
- wdt_rst_in  in  1  WDT reset output; active-high pulse, nominally 4 cycles
- Select  in  1  chip select from the IO address decoder
- Address  in  1  register select: 0 = CAUSE, 1 = CTRL
- Read_enable  in  1  bus read strobe
- Write_enable  in  1  bus write strobe
- Write_data_in  in  16  bus write data
- Read_data_out  out  16  registered read data
- sys_rst  out  1  active-high reset to CPU, WDT and peripherals

Behaviour:
- reset low, sampled on a clock edge:
  - state = HOLD, hold_cnt = HOLD_CYCLES-1, sys_rst = 1.
  - CAUSE = 16'h0001 (bit0 POR), wdt_count = 0, Read_data_out = 0, wdt_prev = 0.
- Event detection:
  - wdt_evt = wdt_rst_in & ~wdt_prev; wdt_prev is registered every cycle. A pulse of any length is one event.
  - sw_evt = Select & Write_enable & Address==1 & Write_data_in==SW_KEY. Any other write to CTRL is ignored.
- FSM, 2 states:
  - HOLD: sys_rst = 1. hold_cnt decrements each cycle. When hold_cnt==0 and there is no event that cycle, go to RUN next cycle.
  - RUN: sys_rst = 0. Any event -> HOLD next cycle with hold_cnt = HOLD_CYCLES-1.
  - An event while in HOLD reloads hold_cnt to HOLD_CYCLES-1 and updates CAUSE.
  - Net effect: sys_rst stays high for exactly HOLD_CYCLES cycles after the last event edge, and rises the cycle after the event is sampled in RUN.
- CAUSE register (read at Address 0):
  - bit0 POR, bit1 WDT, bit2 SW; bits 15:3 always read 0.
  - Sticky. Set by the corresponding event, and NOT cleared by sys_rst.
  - Write-1-to-clear on a write to Address 0.
  - Set and clear in the same cycle: set wins.
- wdt_count:
  - 16-bit, increments on each wdt_evt and saturates at 16'hFFFF.
  - Read at Address 1. Cleared only by reset.
- Reads:
  - Select & Read_enable loads Read_data_out with the addressed register on the next edge (1-cycle latency). Otherwise Read_data_out holds its value.
  - Read and write in the same cycle return the pre-write value.
  - Bus accesses are honoured in both HOLD and RUN.
- reset asserted mid-HOLD or mid-RUN:
  - Everything returns to reset values, including wdt_count.
  - CAUSE = 16'h0001: other bits are dropped.

Test Plan:
1. reset low 3 cycles, then high, no events -> sys_rst=1 for exactly 16 cycles after reset deasserts, then 0; CAUSE read = 16'h0001.
2. In RUN, 4-cycle wdt_rst_in pulse -> sys_rst rises the next cycle and holds 16 cycles; CAUSE = 16'h0003; wdt_count read = 1 (not 4).
3. Write 16'h0003 to Address 0, then write 16'h1234 to Address 1 -> CAUSE = 0, sys_rst stays 0. Then write 16'h5A5A to Address 1 -> sys_rst asserts, CAUSE = 16'h0004.
4. Second WDT pulse 5 cycles into HOLD -> hold reloads, sys_rst high for 16 cycles after the second edge; wdt_count increments by 1.
5. Same-cycle W1C write of 16'h0002 and WDT edge -> CAUSE bit1 remains 1.
6. Preload wdt_count to 16'hFFFF via 65535 pulses, or force it, then one more pulse -> wdt_count stays 16'hFFFF. Then reset low -> wdt_count 0, CAUSE 16'h0001.
